// File: rtl/genius_sprite_seq.sv
// Sprite-flag sequencer between the Genius game controller and the VGA sprite
// renderer. Turns controller events into a one-hot sprite vector with a
// minimum colour hold time, a blank gap between colours, a one-entry pending
// buffer for colours that arrive during that gap, and blinking LOSE/WIN sprites.
module genius_sprite_seq #(
  parameter int NUM_COLORS = 4,
  parameter int CW         = 2,
  parameter int MIN_HOLD   = 8,
  parameter int GAP_FRAMES = 2,
  parameter int BLINK_HALF = 15,
  parameter int TW         = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FRAME_TICK,
  input  logic                  PWR_BTN,
  input  logic                  VGA_FLAG,
  input  logic [CW-1:0]         VGA_COLOR,
  input  logic                  VGA_LOSE,
  input  logic                  VGA_WIN,
  output logic [NUM_COLORS+2:0] SPRITES_FLAGS,
  output logic                  BUSY,
  output logic                  COLOR_ERR
);

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_ON   = 3'd1;
  localparam logic [2:0] ST_SHOW = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_LOSE = 3'd4;
  localparam logic [2:0] ST_WIN  = 3'd5;

  localparam logic [TW-1:0] HOLD_INIT  = TW'(MIN_HOLD);
  localparam logic [TW-1:0] GAP_INIT   = TW'(GAP_FRAMES);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] color_q, color_d;
  logic [TW-1:0] hold_q, hold_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [TW-1:0] blinkCnt_q, blinkCnt_d;
  logic          phase_q, phase_d;
  logic          pendValid_q, pendValid_d;
  logic [CW-1:0] pendColor_q, pendColor_d;
  logic          colorErr_q, colorErr_d;

  logic colorInRange;
  logic validFlag;

  // A colour index is usable only if it names one of the physical pads.
  always_comb begin
    colorInRange = 1'b0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (VGA_COLOR == CW'(i)) colorInRange = 1'b1;
    end
    validFlag = VGA_FLAG && colorInRange;
  end

  // Next-state logic: lose beats win beats everything else, and every
  // entry into LOSE/WIN/SHOW reinitialises the counters it owns.
  always_comb begin
    state_d     = state_q;
    color_d     = color_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    blinkCnt_d  = blinkCnt_q;
    phase_d     = phase_q;
    pendValid_d = pendValid_q;
    pendColor_d = pendColor_q;
    colorErr_d  = VGA_FLAG && !colorInRange &&
                  (state_q == ST_OFF || state_q == ST_ON || state_q == ST_GAP);

    if (VGA_LOSE && state_q != ST_LOSE) begin
      state_d     = ST_LOSE;
      blinkCnt_d  = '0;
      phase_d     = 1'b1;
      hold_d      = '0;
      gap_d       = '0;
      pendValid_d = 1'b0;
    end else if (VGA_WIN && state_q != ST_WIN && state_q != ST_LOSE) begin
      state_d     = ST_WIN;
      blinkCnt_d  = '0;
      phase_d     = 1'b1;
      hold_d      = '0;
      gap_d       = '0;
      pendValid_d = 1'b0;
    end else begin
      case (state_q)
        ST_OFF, ST_ON: begin
          if (state_q == ST_OFF && PWR_BTN) begin
            state_d = ST_ON;
          end else if (validFlag) begin
            state_d = ST_SHOW;
            color_d = VGA_COLOR;
            hold_d  = HOLD_INIT;
          end
        end
        ST_SHOW: begin
          if (FRAME_TICK && hold_q != '0) hold_d = hold_q - 1'b1;
          if (hold_q == '0 && !VGA_FLAG) begin
            if (GAP_FRAMES == 0) begin
              state_d = ST_ON;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_INIT;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            if (pendValid_q) begin
              state_d     = ST_SHOW;
              color_d     = pendColor_q;
              hold_d      = HOLD_INIT;
              pendValid_d = 1'b0;
            end else begin
              state_d = ST_ON;
            end
          end else begin
            if (FRAME_TICK) gap_d = gap_q - 1'b1;
            if (!pendValid_q && validFlag) begin
              pendValid_d = 1'b1;
              pendColor_d = VGA_COLOR;
            end
          end
        end
        ST_LOSE, ST_WIN: begin
          if ((state_q == ST_LOSE && !VGA_LOSE) || (state_q == ST_WIN && !VGA_WIN)) begin
            state_d    = ST_OFF;
            blinkCnt_d = '0;
          end else if (FRAME_TICK) begin
            if (blinkCnt_q == BLINK_LAST) begin
              blinkCnt_d = '0;
              phase_d    = !phase_q;
            end else begin
              blinkCnt_d = blinkCnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State registers with synchronous reset; blink phase rests at 1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_OFF;
      color_q     <= '0;
      hold_q      <= '0;
      gap_q       <= '0;
      blinkCnt_q  <= '0;
      phase_q     <= 1'b1;
      pendValid_q <= 1'b0;
      pendColor_q <= '0;
      colorErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      blinkCnt_q  <= blinkCnt_d;
      phase_q     <= phase_d;
      pendValid_q <= pendValid_d;
      pendColor_q <= pendColor_d;
      colorErr_q  <= colorErr_d;
    end
  end

  // Output decode from registered state only; colour 0 sits at the MSB.
  always_comb begin
    SPRITES_FLAGS = '0;
    case (state_q)
      ST_ON, ST_GAP: SPRITES_FLAGS[0] = 1'b1;
      ST_SHOW: begin
        SPRITES_FLAGS[0] = 1'b1;
        for (int i = 0; i < NUM_COLORS; i++) begin
          if (color_q == CW'(i)) SPRITES_FLAGS[NUM_COLORS+2-i] = 1'b1;
        end
      end
      ST_WIN:  SPRITES_FLAGS[1] = phase_q;
      ST_LOSE: SPRITES_FLAGS[2] = phase_q;
      default: SPRITES_FLAGS = '0;
    endcase
    BUSY      = (state_q == ST_SHOW) || (state_q == ST_GAP);
    COLOR_ERR = colorErr_q;
  end

endmodule

// File: tb/tb_genius_sprite_seq.sv
// Directed bench for genius_sprite_seq: a default 4-colour instance driven
// from a vector table plus hand sequences, and a 5-colour instance for
// out-of-range colour handling and reset during the gap.
module tb_genius_sprite_seq;

  typedef struct {
    logic       rst;
    logic       pwr;
    logic       flag;
    logic [1:0] color;
    logic       lose;
    logic       win;
    logic       tick;
    logic [6:0] expFlags;
    logic       expBusy;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset, frameTick, pwrBtn, vgaFlag, vgaLose, vgaWin;
  logic [1:0] vgaColor;
  logic [6:0] spritesFlags;
  logic       busy, colorErr;

  logic       reset5, frameTick5, pwrBtn5, vgaFlag5, vgaLose5, vgaWin5;
  logic [2:0] vgaColor5;
  logic [7:0] spritesFlags5;
  logic       busy5, colorErr5;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  // Free-running 10-unit clock shared by both instances.
  always #5 clock = ~clock;

  genius_sprite_seq dut (
    .CLK(clock), .RESET(reset), .FRAME_TICK(frameTick), .PWR_BTN(pwrBtn),
    .VGA_FLAG(vgaFlag), .VGA_COLOR(vgaColor), .VGA_LOSE(vgaLose), .VGA_WIN(vgaWin),
    .SPRITES_FLAGS(spritesFlags), .BUSY(busy), .COLOR_ERR(colorErr)
  );

  genius_sprite_seq #(.NUM_COLORS(5), .CW(3)) dut5 (
    .CLK(clock), .RESET(reset5), .FRAME_TICK(frameTick5), .PWR_BTN(pwrBtn5),
    .VGA_FLAG(vgaFlag5), .VGA_COLOR(vgaColor5), .VGA_LOSE(vgaLose5), .VGA_WIN(vgaWin5),
    .SPRITES_FLAGS(spritesFlags5), .BUSY(busy5), .COLOR_ERR(colorErr5)
  );

  // Drive one cycle of inputs on the default instance and step past the edge.
  task automatic applyStimulus(input vec_t v);
    reset = v.rst; pwrBtn = v.pwr; vgaFlag = v.flag; vgaColor = v.color;
    vgaLose = v.lose; vgaWin = v.win; frameTick = v.tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expFlags,
                             input logic expBusy, input logic expErr);
    checks++;
    if ({spritesFlags, busy, colorErr} !== {expFlags, expBusy, expErr}) begin
      failures++;
      $display("[TB] FAIL %s: flags=%b busy=%b err=%b, expected flags=%b busy=%b err=%b",
               name, spritesFlags, busy, colorErr, expFlags, expBusy, expErr);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic f, input logic [1:0] c,
                      input logic l, input logic w, input logic t);
    vec_t v;
    v = '{r, p, f, c, l, w, t, 7'b0, 1'b0};
    applyStimulus(v);
  endtask

  task automatic step5(input logic r, input logic p, input logic f, input logic [2:0] c,
                       input logic t);
    reset5 = r; pwrBtn5 = p; vgaFlag5 = f; vgaColor5 = c; frameTick5 = t;
    vgaLose5 = 1'b0; vgaWin5 = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput5(input string name, input logic [7:0] expFlags,
                              input logic expBusy, input logic expErr);
    checks++;
    if ({spritesFlags5, busy5, colorErr5} !== {expFlags, expBusy, expErr}) begin
      failures++;
      $display("[TB] FAIL %s: flags=%b busy=%b err=%b, expected flags=%b busy=%b err=%b",
               name, spritesFlags5, busy5, colorErr5, expFlags, expBusy, expErr);
    end
  endtask

  initial begin
    reset5 = 1'b1; pwrBtn5 = 1'b0; vgaFlag5 = 1'b0; vgaColor5 = 3'd0;
    frameTick5 = 1'b0; vgaLose5 = 1'b0; vgaWin5 = 1'b0;

    // reset with busy inputs, power on, then a one-cycle colour-2 pulse
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 7'b0000000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 7'b0010001, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 7'b0010001, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expFlags, vecs[i].expBusy, 1'b0);
    end

    // remaining 7 ticks of the 8-tick hold, then 2-tick gap, then ON
    for (int i = 2; i <= 8; i++) begin
      step(0, 0, 0, 2'd0, 0, 0, 1);
      checkOutput($sformatf("hold_tick%0d", i), 7'b0010001, 1'b1, 1'b0);
    end
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("gap_enter", 7'b0000001, 1'b1, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 1); checkOutput("gap_tick1", 7'b0000001, 1'b1, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 1); checkOutput("gap_tick2", 7'b0000001, 1'b1, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("gap_to_on", 7'b0000001, 1'b0, 1'b0);

    // colour 0 latched; colour changes while the flag is held are ignored
    step(0, 0, 1, 2'd0, 0, 0, 0); checkOutput("show_c0", 7'b1000001, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1, 2'd3, 0, 0, 1);
      checkOutput($sformatf("held_c0_%0d", i), 7'b1000001, 1'b1, 1'b0);
    end
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("held_drop", 7'b0000001, 1'b1, 1'b0);

    // colour 1 arriving during the gap goes straight to SHOW afterwards
    step(0, 0, 1, 2'd1, 0, 0, 0); checkOutput("pend_cap", 7'b0000001, 1'b1, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 1); checkOutput("pend_g1", 7'b0000001, 1'b1, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 1); checkOutput("pend_g2", 7'b0000001, 1'b1, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("pend_show", 7'b0100001, 1'b1, 1'b0);

    // lose pre-empts SHOW and blinks every 15 ticks; win alongside keeps LOSE
    step(0, 0, 0, 2'd0, 1, 0, 0); checkOutput("lose_enter", 7'b0000100, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      step(0, 0, 0, 2'd0, 1, (i >= 5), 1);
      checkOutput($sformatf("blink%0d", i), ((i / 15) % 2 == 0) ? 7'b0000100 : 7'b0000000,
                  1'b0, 1'b0);
    end
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("lose_exit", 7'b0000000, 1'b0, 1'b0);
    step(0, 0, 0, 2'd0, 0, 1, 0); checkOutput("win_enter", 7'b0000010, 1'b0, 1'b0);
    step(0, 0, 0, 2'd0, 1, 1, 0); checkOutput("win_to_lose", 7'b0000100, 1'b0, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("both_off", 7'b0000000, 1'b0, 1'b0);

    // reset wins over a SHOW in progress
    step(0, 1, 0, 2'd0, 0, 0, 0); checkOutput("repower", 7'b0000001, 1'b0, 1'b0);
    step(0, 0, 1, 2'd3, 0, 0, 0); checkOutput("show_c3", 7'b0001001, 1'b1, 1'b0);
    step(1, 0, 1, 2'd3, 0, 0, 1); checkOutput("rst_mid_show", 7'b0000000, 1'b0, 1'b0);
    step(0, 0, 0, 2'd0, 0, 0, 0); checkOutput("after_rst", 7'b0000000, 1'b0, 1'b0);

    // five-colour instance: out-of-range colour handling
    step5(1, 0, 0, 3'd0, 0); checkOutput5("c5_reset", 8'b00000000, 1'b0, 1'b0);
    step5(0, 1, 0, 3'd0, 0); checkOutput5("c5_on", 8'b00000001, 1'b0, 1'b0);
    step5(0, 0, 1, 3'd6, 0); checkOutput5("c5_err1", 8'b00000001, 1'b0, 1'b1);
    step5(0, 0, 1, 3'd6, 0); checkOutput5("c5_err2", 8'b00000001, 1'b0, 1'b1);
    step5(0, 0, 0, 3'd0, 0); checkOutput5("c5_err_clr", 8'b00000001, 1'b0, 1'b0);
    step5(0, 0, 1, 3'd4, 0); checkOutput5("c5_show4", 8'b00001001, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step5(0, 0, 0, 3'd0, 1);
      checkOutput5($sformatf("c5_hold%0d", i), 8'b00001001, 1'b1, 1'b0);
    end
    step5(0, 0, 0, 3'd0, 0); checkOutput5("c5_gap", 8'b00000001, 1'b1, 1'b0);
    step5(0, 0, 1, 3'd7, 0); checkOutput5("c5_gap_err", 8'b00000001, 1'b1, 1'b1);
    step5(0, 0, 0, 3'd0, 1); checkOutput5("c5_gap_t1", 8'b00000001, 1'b1, 1'b0);
    step5(0, 0, 0, 3'd0, 1); checkOutput5("c5_gap_t2", 8'b00000001, 1'b1, 1'b0);
    step5(0, 0, 0, 3'd0, 0); checkOutput5("c5_no_pend", 8'b00000001, 1'b0, 1'b0);
    step5(0, 0, 1, 3'd0, 0); checkOutput5("c5_show0", 8'b10000001, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step5(0, 0, 0, 3'd0, 1);
    end
    step5(0, 0, 0, 3'd0, 0); checkOutput5("c5_gap2", 8'b00000001, 1'b1, 1'b0);
    step5(0, 0, 0, 3'd0, 1); checkOutput5("c5_gap2_t1", 8'b00000001, 1'b1, 1'b0);
    step5(1, 0, 1, 3'd2, 1); checkOutput5("c5_rst_gap", 8'b00000000, 1'b0, 1'b0);
    step5(0, 0, 0, 3'd0, 0); checkOutput5("c5_after_rst", 8'b00000000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/genius_sprite_seq.md
Name: genius_sprite_seq

Overview:
Clocked, parametrised sprite-flag sequencer between the Genius game controller and the VGA sprite renderer. It converts controller events into a registered one-hot sprite-flag vector:
- colour press/playback events,
- lose and win events,
- power button.

Beyond a level follower, it adds:
- a minimum on-screen hold time, counted in video frames;
- a blank gap between consecutive colours, so repeated colours stay distinguishable;
- a one-entry pending buffer for events that arrive during the gap;
- blinking LOSE/WIN sprites.

Parameters:
- NUM_COLORS, 4, number of colour pads/sprites (≥2).
- CW, 2, width of colour index; must satisfy 2^CW ≥ NUM_COLORS.
- MIN_HOLD, 8, minimum frames a colour sprite stays lit (≥1).
- GAP_FRAMES, 2, frames of blank (PWR-only) display after a colour; 0 = no gap.
- BLINK_HALF, 15, frames per blink half-period for LOSE/WIN (≥1).
- TW, 8, width of frame counters; 2^TW > max(MIN_HOLD, GAP_FRAMES, BLINK_HALF).

Ports:
- CLK, in, 1, system clock.
- RESET, in, 1, reset; synchronous, active-high.
- FRAME_TICK, in, 1, one-cycle pulse per video frame; all frame counts advance only on it.
- PWR_BTN, in, 1, power-on request (level; sampled per cycle).
- VGA_FLAG, in, 1, colour event valid (level).
- VGA_COLOR, in, CW, colour index qualified by VGA_FLAG.
- VGA_LOSE, in, 1, lose indication (level).
- VGA_WIN, in, 1, win indication (level).
- SPRITES_FLAGS, out, NUM_COLORS+3:
  - bit 0 = PWR, bit 1 = WIN, bit 2 = LOSE;
  - colour i at bit NUM_COLORS+2-i, so colour 0 is the MSB.
- BUSY, out, 1, high in SHOW or GAP.
- COLOR_ERR, out, 1, one-cycle pulse when a VGA_FLAG event carries index ≥ NUM_COLORS.

Behaviour:

Reset and timing
- RESET is sampled at the CLK edge.
- Reset values: state=OFF, SPRITES_FLAGS=0, BUSY=0, COLOR_ERR=0, all counters=0, pending empty, blink phase=1.
- RESET has priority over every other input, including mid-SHOW and mid-blink.
- Conditions sampled at edge k take effect from edge k.
- SPRITES_FLAGS and BUSY decode only registered state/phase: no combinational input-to-output path.

States
- OFF: flags all 0.
  - Priority: VGA_LOSE→LOSE; VGA_WIN→WIN; PWR_BTN→ON; valid VGA_FLAG→SHOW.
- ON: PWR bit only.
  - Priority: LOSE → WIN → valid VGA_FLAG→SHOW.
- SHOW: PWR bit plus the latched colour bit.
  - On entry: latch colour, load hold=MIN_HOLD.
  - hold decrements on each FRAME_TICK and saturates at 0.
  - Exit when hold==0 and VGA_FLAG==0: go to GAP with gap=GAP_FRAMES, or to ON if GAP_FRAMES==0.
  - VGA_COLOR changes while VGA_FLAG stays high are ignored; the latched colour is held.
  - A short VGA_FLAG pulse still yields exactly MIN_HOLD frame ticks of display.
- GAP: PWR bit only.
  - gap decrements on FRAME_TICK.
  - While pending is empty, a valid VGA_FLAG=1 latches VGA_COLOR into pending (first event wins).
  - When gap reaches 0: go to SHOW with the pending colour if pending is full (pending cleared), else to ON.
- LOSE: LOSE bit = blink phase; other bits 0.
  - Phase starts at 1 on entry and toggles every BLINK_HALF frame ticks.
  - Stay while VGA_LOSE=1; on VGA_LOSE=0 go to OFF.
- WIN: same as LOSE, using the WIN bit and VGA_WIN.
  - VGA_LOSE=1 while in WIN → LOSE.

Global rules
- Pre-emption: VGA_LOSE=1 (then VGA_WIN=1) forces LOSE (WIN) from ON, SHOW and GAP on the next edge. Pending and hold are cleared.
- Both VGA_LOSE and VGA_WIN high resolves to LOSE.
- Invalid index:
  - VGA_FLAG with VGA_COLOR ≥ NUM_COLORS in OFF/ON/GAP is ignored (no state change, no pending).
  - It pulses COLOR_ERR for one cycle per cycle it is sampled.
  - In SHOW it is not checked.
- Counter arithmetic is unsigned TW-bit with no wrap: decrement is suppressed at 0.

Test Plan:
1. RESET=1 for 2 cycles with random inputs → SPRITES_FLAGS=7'b0000000, BUSY=0; then PWR_BTN=1 for 1 cycle → flags 7'b0000001 from the next edge.
2. In ON, a VGA_FLAG=1 / VGA_COLOR=2 pulse lasting 1 cycle → flags 7'b0010001 for exactly 8 FRAME_TICKs. Then 7'b0000001 (BUSY=1) for 2 ticks, then ON with BUSY=0.
3. In SHOW(colour 0), VGA_COLOR changes to 3 with the flag held for 20 ticks → flags stay 7'b1000001 until the flag drops, then GAP.
4. During GAP, VGA_FLAG=1 / VGA_COLOR=1 → after the gap expires, flags 7'b0100001 with no intermediate ON cycle.
5. VGA_LOSE=1 mid-SHOW → flags 7'b0000100 next edge; LOSE bit toggles every 15 ticks. Raising VGA_WIN simultaneously keeps LOSE. Dropping VGA_LOSE → 7'b0000000.
6. NUM_COLORS=5/CW=3 build: VGA_COLOR=6 in ON → COLOR_ERR pulses, state unchanged. Then RESET asserted mid-GAP → all outputs 0 next edge.
